// File: rtl/cpu_step_pkg.sv
// ---------------------------------------------------------------------------
// cpu_step_pkg
// Shared definitions for the CPU run controller: the 2-bit run-mode codes
// carried on mode_i and the encodings of the CPU reset sequencer states.
// ---------------------------------------------------------------------------
package cpu_step_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_RUN   = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // HOLD keeps the CPU in reset; RUN lets enables through.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } rst_state_e;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button into clk and accepts a new level only after
// DB_CYCLES consecutive synchronised samples that differ from the current
// level; a single sample equal to the current level restarts the count.
// Ports:
//   clk      in   board clock
//   reset    in   asynchronous, active-low
//   raw_i    in   raw, asynchronous button input
//   level_o  out  debounced button level
//   press_o  out  one-cycle pulse on an accepted 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // This is the DB_CYCLES-th differing sample in a row: accept it.
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
// Board-level run controller for the single-cycle CPU. Produces a CPU reset
// held RST_HOLD cycles after board reset and a one-cycle CPU clock-enable in
// halt, single-step, divided free-run or counted-burst mode.
// Optional feature: define CPU_RST_BTN_EN to add a debounced reset button
// (btn_rst_i) whose press re-enters the reset hold sequence.
// Ports:
//   clk          in   board clock (sole clock)
//   reset        in   asynchronous, active-low
//   mode_i       in   00 halt, 01 single-step, 10 free-run, 11 burst
//   div_i        in   enable period minus 1 for free-run / burst
//   burst_len_i  in   enables per burst, sampled on an accepted press
//   btn_step_i   in   raw step / burst-start button
//   btn_rst_i    in   raw CPU reset button (CPU_RST_BTN_EN only)
//   cpu_clk_en_o out  CPU clock-enable qualifier
//   cpu_reset_o  out  active-high synchronous CPU reset
//   step_cnt_o   out  enables since cpu_reset_o fell (wrapping)
//   busy_o       out  burst in progress
// ---------------------------------------------------------------------------
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DIV_W     = 24,
    parameter int DB_CYCLES = 16,
    parameter int RST_HOLD  = 4,
    parameter int BURST_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               btn_step_i,
`ifdef CPU_RST_BTN_EN
    input  logic               btn_rst_i,
`endif
    output logic               cpu_clk_en_o,
    output logic               cpu_reset_o,
    output logic [31:0]        step_cnt_o,
    output logic               busy_o
);

    localparam int HW = $clog2(RST_HOLD + 1);

    rst_state_e         state_q, state_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic [31:0]        step_cnt_q, step_cnt_d;

    logic step_level, step_press;
    logic rst_level, rst_press;
    logic mode_chg, term;
    logic unused_levels;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_step_i),
        .level_o (step_level),
        .press_o (step_press)
    );

`ifdef CPU_RST_BTN_EN
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_rst_i),
        .level_o (rst_level),
        .press_o (rst_press)
    );
`else
    assign rst_level = 1'b0;
    assign rst_press = 1'b0;
`endif

    // Only the press pulses drive the controller; the levels are kept for debug.
    assign unused_levels = step_level ^ rst_level;

    assign mode_chg = (mode_i != mode_q);
    // ">=" so that shrinking div_i below the running count reloads at once.
    assign term     = (div_q >= div_i);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        mode_d     = mode_i;
        div_d      = div_q;
        burst_d    = burst_q;
        busy_d     = busy_q;
        en_d       = 1'b0;
        step_cnt_d = step_cnt_q;

        if (state_q == ST_HOLD) begin
            div_d      = '0;
            burst_d    = '0;
            busy_d     = 1'b0;
            step_cnt_d = '0;
            if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
                state_d    = ST_RUN;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end else begin
            step_cnt_d = step_cnt_q + 32'(en_q);
            if (mode_chg) begin
                // Any mode change restarts timing; a coincident press is lost.
                div_d   = '0;
                burst_d = '0;
                busy_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_STEP: begin
                        div_d = '0;
                        en_d  = step_press;
                    end
                    MODE_RUN: begin
                        if (term) begin
                            div_d = '0;
                            en_d  = 1'b1;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                    MODE_BURST: begin
                        if (busy_q) begin
                            // burst_q reaches 0 in the cycle the last enable
                            // is visible; busy drops one cycle later.
                            if (burst_q == '0) begin
                                busy_d = 1'b0;
                                div_d  = '0;
                            end else if (term) begin
                                div_d   = '0;
                                en_d    = 1'b1;
                                burst_d = burst_q - BURST_W'(1);
                            end else begin
                                div_d = div_q + DIV_W'(1);
                            end
                        end else begin
                            div_d = '0;
                            if (step_press && (burst_len_i != '0)) begin
                                burst_d = burst_len_i;
                                busy_d  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        div_d = '0;
                    end
                endcase
            end

            if (rst_press) begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
                div_d      = '0;
                burst_d    = '0;
                busy_d     = 1'b0;
                en_d       = 1'b0;
                step_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            mode_q     <= MODE_HALT;
            div_q      <= '0;
            burst_q    <= '0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            burst_q    <= burst_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign cpu_reset_o  = (state_q == ST_HOLD);
    assign cpu_clk_en_o = en_q & ~cpu_reset_o;
    assign step_cnt_o   = step_cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_ctrl
// Directed bench for cpu_step_ctrl: reset hold, single-step with clean and
// bouncing presses, free-run rates, bursts, mode change and reset mid-burst,
// and (with CPU_RST_BTN_EN) the CPU reset button.
// ---------------------------------------------------------------------------
module tb_cpu_step_ctrl;
    import cpu_step_pkg::*;

    localparam int DIV_W   = 24;
    localparam int BURST_W = 16;

    logic               clk;
    logic               reset;
    logic [1:0]         mode_i;
    logic [DIV_W-1:0]   div_i;
    logic [BURST_W-1:0] burst_len_i;
    logic               btn_step_i;
`ifdef CPU_RST_BTN_EN
    logic               btn_rst_i;
`endif
    logic               cpu_clk_en_o;
    logic               cpu_reset_o;
    logic [31:0]        step_cnt_o;
    logic               busy_o;

    cpu_step_ctrl #(
        .DIV_W     (DIV_W),
        .DB_CYCLES (16),
        .RST_HOLD  (4),
        .BURST_W   (BURST_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_i       (mode_i),
        .div_i        (div_i),
        .burst_len_i  (burst_len_i),
        .btn_step_i   (btn_step_i),
`ifdef CPU_RST_BTN_EN
        .btn_rst_i    (btn_rst_i),
`endif
        .cpu_clk_en_o (cpu_clk_en_o),
        .cpu_reset_o  (cpu_reset_o),
        .step_cnt_o   (step_cnt_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse statistics for the current observation window.
    int w_idx, w_pulses, w_first, w_last, w_mingap, w_maxgap, w_busy_bad, w_busy_n;
    int en_seen = 0;

    always @(negedge clk) if (cpu_clk_en_o) en_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic w_clear();
        w_idx = 0; w_pulses = 0; w_first = -1; w_last = -1;
        w_mingap = 100000; w_maxgap = 0; w_busy_bad = 0; w_busy_n = 0;
    endtask

    // Called right after a negedge: record one cycle of outputs.
    task automatic samp();
        int gap;
        w_idx++;
        if (busy_o) w_busy_n++;
        if (cpu_clk_en_o) begin
            if (w_pulses > 0) begin
                gap = w_idx - w_last;
                if (gap < w_mingap) w_mingap = gap;
                if (gap > w_maxgap) w_maxgap = gap;
            end else begin
                w_first = w_idx;
            end
            w_last = w_idx;
            w_pulses++;
            if (!busy_o) w_busy_bad++;
        end
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            samp();
        end
    endtask

    // Drive the step button for 'total' cycles: held high 'hold' cycles,
    // optionally with 5 one-cycle glitches before and after the hold.
    task automatic press_watch(input int hold, input int total, input bit bounce);
        int on_end;
        on_end = bounce ? hold + 10 : hold;
        for (int i = 0; i < total; i++) begin
            if (bounce && i < 10)                 btn_step_i = (i % 2 == 0);
            else if (i < on_end)                  btn_step_i = 1'b1;
            else if (bounce && i < on_end + 5)    btn_step_i = (i % 2 == 1);
            else                                  btn_step_i = 1'b0;
            @(negedge clk);
            samp();
        end
        btn_step_i = 1'b0;
    endtask

    initial begin
        int rc;
        reset       = 1'b0;
        mode_i      = MODE_HALT;
        div_i       = '0;
        burst_len_i = '0;
        btn_step_i  = 1'b0;
`ifdef CPU_RST_BTN_EN
        btn_rst_i   = 1'b0;
`endif
        // ---------------- reset and hold sequence ----------------
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset_o), 1);
        chk("rst_en", 32'(cpu_clk_en_o), 0);
        chk("rst_step_cnt", step_cnt_o, 0);
        chk("rst_busy", 32'(busy_o), 0);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold_cpu_reset_%0d", k), 32'(cpu_reset_o), (k < 4) ? 1 : 0);
            chk($sformatf("hold_en_%0d", k), 32'(cpu_clk_en_o), 0);
        end

        // ---------------- halt: presses discarded ----------------
        w_clear();
        press_watch(20, 45, 1'b0);
        chk("halt_press_pulses", w_pulses, 0);

        // ---------------- single step ----------------
        mode_i = MODE_STEP;
        repeat (2) @(negedge clk);
        w_clear();
        press_watch(20, 45, 1'b0);
        chk("step_clean_pulses", w_pulses, 1);
        chk("step_clean_cnt", step_cnt_o, 1);
        w_clear();
        press_watch(20, 60, 1'b1);
        chk("step_bounce_pulses", w_pulses, 1);
        chk("step_bounce_cnt", step_cnt_o, 2);

        // ---------------- free run ----------------
        w_clear();
        mode_i = MODE_RUN;
        div_i  = 24'd2;
        watch(12);
        chk("run2_first", w_first, 4);
        chk("run2_pulses", w_pulses, 3);
        chk("run2_gap", w_maxgap, 3);
        chk("run2_cnt", step_cnt_o, 5);
        div_i = 24'd0;
        w_clear();
        watch(10);
        chk("run0_pulses", w_pulses, 10);
        chk("run0_gap", w_maxgap, 1);
        mode_i = MODE_HALT;
        w_clear();
        watch(3);
        chk("run_halt_pulses", w_pulses, 0);
        chk("run_total_cnt", step_cnt_o, 15);
        chk("run_cnt_vs_seen", step_cnt_o, 32'(en_seen));

        // ---------------- burst len 5 div 1 ----------------
        mode_i      = MODE_BURST;
        div_i       = 24'd1;
        burst_len_i = 16'd5;
        repeat (3) @(negedge clk);
        w_clear();
        press_watch(20, 45, 1'b0);
        chk("burst_pulses", w_pulses, 5);
        chk("burst_mingap", w_mingap, 2);
        chk("burst_maxgap", w_maxgap, 2);
        chk("burst_busy_on_en", w_busy_bad, 0);
        chk("burst_busy_end", 32'(busy_o), 0);

        // ---------------- burst length 0 is a no-op ----------------
        burst_len_i = 16'd0;
        w_clear();
        press_watch(20, 45, 1'b0);
        chk("burst0_pulses", w_pulses, 0);
        chk("burst0_busy", w_busy_n, 0);

        // ---------------- second press mid-burst ignored ----------------
        burst_len_i = 16'd5;
        div_i       = 24'd15;
        w_clear();
        for (int i = 0; i < 160; i++) begin
            btn_step_i = (i < 20) || (i >= 45 && i < 70);
            @(negedge clk);
            samp();
        end
        btn_step_i = 1'b0;
        chk("burst2_pulses", w_pulses, 5);
        chk("burst2_gap", w_maxgap, 16);
        chk("burst2_mingap", w_mingap, 16);
        chk("burst2_busy_end", 32'(busy_o), 0);

        // ---------------- halt mid-burst ----------------
        div_i = 24'd3;
        w_clear();
        for (int i = 0; i < 80 && w_pulses < 2; i++) begin
            btn_step_i = (i < 20);
            @(negedge clk);
            samp();
        end
        btn_step_i = 1'b0;
        chk("halt_mid_seen2", w_pulses, 2);
        mode_i = MODE_HALT;
        @(negedge clk);
        chk("halt_mid_busy", 32'(busy_o), 0);
        w_clear();
        watch(30);
        chk("halt_mid_pulses", w_pulses, 0);

        // ---------------- reset mid-burst ----------------
        mode_i = MODE_BURST;
        div_i  = 24'd1;
        repeat (3) @(negedge clk);
        w_clear();
        for (int i = 0; i < 80 && w_pulses < 1; i++) begin
            btn_step_i = (i < 20);
            @(negedge clk);
            samp();
        end
        btn_step_i = 1'b0;
        chk("rmid_seen1", w_pulses, 1);
        chk("rmid_busy_before", 32'(busy_o), 1);
        reset = 1'b0;
        #1;
        chk("rmid_cpu_reset", 32'(cpu_reset_o), 1);
        chk("rmid_en", 32'(cpu_clk_en_o), 0);
        chk("rmid_step_cnt", step_cnt_o, 0);
        chk("rmid_busy", 32'(busy_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rmid_hold_%0d", k), 32'(cpu_reset_o), (k < 4) ? 1 : 0);
        end
        w_clear();
        watch(20);
        chk("rmid_after_pulses", w_pulses, 0);
        chk("rmid_after_cnt", step_cnt_o, 0);

`ifdef CPU_RST_BTN_EN
        // ---------------- CPU reset button in free run ----------------
        mode_i = MODE_RUN;
        div_i  = 24'd2;
        repeat (10) @(negedge clk);
        rc = 0;
        for (int i = 0; i < 60; i++) begin
            btn_rst_i = (i < 20);
            @(negedge clk);
            if (cpu_reset_o) begin
                if (rc == 0) chk("rbtn_cnt_cleared", step_cnt_o, 0);
                rc++;
            end else if (rc > 0) begin
                break;
            end
        end
        btn_rst_i = 1'b0;
        chk("rbtn_hold_cycles", rc, 4);
        w_clear();
        watch(10);
        chk("rbtn_resume_pulses", w_pulses, 3);
        chk("rbtn_resume_first", w_first, 3);
`else
        rc = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
